// File: rtl/tt_asiclab_accum.sv
// Handshaked add/sub/accumulate unit with registered result, overflow flag and accumulator.
// Define ACCUM_SAT_EN for saturating arithmetic; otherwise results wrap modulo 2^WIDTH.
module tt_asiclab_accum #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic [WIDTH-1:0] acc
);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ACC  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    logic             accept;
    logic             deliver;
    logic [WIDTH:0]   sum_ab;
    logic [WIDTH:0]   diff_ab;
    logic [WIDTH:0]   sum_acc;
    logic [WIDTH-1:0] next_res;
    logic             next_ovf;

    assign in_ready = rst_n && ena && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign deliver  = out_valid && out_ready;

    // Top bit of each widened result is the carry (add) or borrow (sub).
    assign sum_ab  = {1'b0, a} + {1'b0, b};
    assign diff_ab = {1'b0, a} - {1'b0, b};
    assign sum_acc = {1'b0, acc} + {1'b0, a};

    always_comb begin
        next_res = '0;
        next_ovf = 1'b0;
        unique case (op)
            OP_ADD: begin
                next_ovf = sum_ab[WIDTH];
`ifdef ACCUM_SAT_EN
                next_res = sum_ab[WIDTH] ? '1 : sum_ab[WIDTH-1:0];
`else
                next_res = sum_ab[WIDTH-1:0];
`endif
            end
            OP_SUB: begin
                next_ovf = diff_ab[WIDTH];
`ifdef ACCUM_SAT_EN
                next_res = diff_ab[WIDTH] ? '0 : diff_ab[WIDTH-1:0];
`else
                next_res = diff_ab[WIDTH-1:0];
`endif
            end
            OP_ACC: begin
                next_ovf = sum_acc[WIDTH];
`ifdef ACCUM_SAT_EN
                next_res = sum_acc[WIDTH] ? '1 : sum_acc[WIDTH-1:0];
`else
                next_res = sum_acc[WIDTH-1:0];
`endif
            end
            OP_LOAD: begin
                next_ovf = 1'b0;
                next_res = a;
            end
            default: begin
                next_ovf = 1'b0;
                next_res = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result    <= '0;
            ovf       <= 1'b0;
            acc       <= '0;
            out_valid <= 1'b0;
        end else if (ena) begin
            if (accept) begin
                result    <= next_res;
                ovf       <= next_ovf;
                out_valid <= 1'b1;
                if (op == OP_ACC || op == OP_LOAD) begin
                    acc <= next_res;
                end
            end else if (deliver) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tt_asiclab_accum.sv
// Self-checking bench for tt_asiclab_accum: directed test-plan steps then random traffic.
// Expected values follow ACCUM_SAT_EN when it is defined for the build.
module tb_tt_asiclab_accum;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       ovf;
    logic [7:0] acc;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, as plain integers.
    int m_res, m_ovf, m_acc, m_valid;

`ifdef ACCUM_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    tt_asiclab_accum #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .ovf(ovf), .acc(acc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit r, input bit e, input bit v, input int o,
                         input int av, input int bv, input bit ordy);
        rst_n     = r;
        ena       = e;
        in_valid  = v;
        op        = 2'(o);
        a         = 8'(av);
        b         = 8'(bv);
        out_ready = ordy;
    endtask

    // Arithmetic straight from the operation rules, on integers.
    task automatic model_op(input int o, input int av, input int bv,
                            output int res, output int of);
        int s;
        case (o)
            0: begin s = av + bv;  of = (s > 255); res = (SAT && of) ? 255 : s % 256; end
            1: begin of = (av < bv); res = (SAT && of) ? 0 : (av - bv + 256) % 256; end
            2: begin s = m_acc + av; of = (s > 255); res = (SAT && of) ? 255 : s % 256; end
            default: begin of = 0; res = av; end
        endcase
    endtask

    task automatic tick(input string tag);
        int exp_rdy, res, of;
        #1;
        exp_rdy = (rst_n && ena && (!m_valid || out_ready)) ? 1 : 0;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
        if (!rst_n) begin
            m_res = 0; m_ovf = 0; m_acc = 0; m_valid = 0;
        end else if (ena) begin
            if (in_valid && exp_rdy != 0) begin
                model_op(int'(op), int'(a), int'(b), res, of);
                m_res = res;
                m_ovf = of;
                m_valid = 1;
                if (op >= 2) m_acc = res;
            end else if (m_valid != 0 && out_ready) begin
                m_valid = 0;
            end
        end
        @(posedge clk);
        #1;
        chk({tag, ".result"}, 32'(result), 32'(m_res));
        chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
        chk({tag, ".acc"}, 32'(acc), 32'(m_acc));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    endtask

    initial begin
        m_res = 0; m_ovf = 0; m_acc = 0; m_valid = 0;
        drive(0, 1, 0, 0, 0, 0, 1);
        @(posedge clk);
        #1;

        // Reset state
        tick("reset");
        chk("reset.result_k", 32'(result), 0);
        chk("reset.valid_k", 32'(out_valid), 0);

        // ADD with carry out
        drive(1, 1, 1, 0, 200, 100, 1);
        tick("add200");
        chk("add200.result_k", 32'(result), SAT ? 255 : 44);
        chk("add200.ovf_k", 32'(ovf), 1);
        chk("add200.valid_k", 32'(out_valid), 1);

        // SUB with and without borrow
        drive(1, 1, 1, 1, 5, 10, 1);
        tick("sub5_10");
        chk("sub5_10.result_k", 32'(result), SAT ? 0 : 251);
        chk("sub5_10.ovf_k", 32'(ovf), 1);
        drive(1, 1, 1, 1, 10, 5, 1);
        tick("sub10_5");
        chk("sub10_5.result_k", 32'(result), 5);
        chk("sub10_5.ovf_k", 32'(ovf), 0);

        // LOAD / ACC chain
        drive(1, 1, 1, 3, 10, 0, 1);
        tick("load10");
        chk("load10.result_k", 32'(result), 10);
        drive(1, 1, 1, 2, 20, 0, 1);
        tick("acc20");
        chk("acc20.result_k", 32'(result), 30);
        chk("acc20.ovf_k", 32'(ovf), 0);
        drive(1, 1, 1, 2, 250, 0, 1);
        tick("acc250");
        chk("acc250.result_k", 32'(result), SAT ? 255 : 24);
        chk("acc250.ovf_k", 32'(ovf), 1);
        chk("acc250.acc_k", 32'(acc), SAT ? 255 : 24);

        // Back-pressure
        drive(1, 1, 1, 0, 1, 2, 1);
        tick("bp_add");
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 0, 9, 9, 0);
            tick("bp_hold");
            chk("bp_hold.result_k", 32'(result), 3);
            chk("bp_hold.valid_k", 32'(out_valid), 1);
            chk("bp_hold.in_ready_k", 32'(in_ready), 0);
        end
        drive(1, 1, 1, 0, 4, 4, 1);
        #1;
        chk("bp_release.in_ready_k", 32'(in_ready), 1);
        tick("bp_release");
        chk("bp_release.result_k", 32'(result), 8);
        chk("bp_release.valid_k", 32'(out_valid), 1);

        // Reset mid-operation
        drive(1, 1, 1, 3, 30, 0, 1);
        tick("mid_load");
        drive(1, 1, 0, 0, 0, 0, 0);
        tick("mid_hold");
        chk("mid_hold.acc_k", 32'(acc), 30);
        drive(0, 1, 1, 0, 1, 1, 0);
        tick("mid_reset");
        chk("mid_reset.valid_k", 32'(out_valid), 0);
        chk("mid_reset.acc_k", 32'(acc), 0);
        chk("mid_reset.result_k", 32'(result), 0);
        chk("mid_reset.ovf_k", 32'(ovf), 0);

        // Enable low freezes everything, including the deliver
        drive(1, 1, 1, 0, 3, 3, 0);
        tick("ena_pre");
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 3, 77, 0, 1);
            tick("ena_low");
            chk("ena_low.in_ready_k", 32'(in_ready), 0);
            chk("ena_low.valid_k", 32'(out_valid), 1);
            chk("ena_low.result_k", 32'(result), 6);
            chk("ena_low.acc_k", 32'(acc), 0);
        end
        drive(1, 1, 1, 3, 77, 0, 1);
        tick("ena_high");
        chk("ena_high.acc_k", 32'(acc), 77);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  ($urandom_range(0, 2) != 0));
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
